rgb_matrix_scanner: RTL

- Downstream display stage for the 8x8 RGB LED matrix game.
- Game logic (plate, coins, win/lose screens) writes full frames into a double-buffered frame store.
- This block row-scans the front frame onto the matrix pins: DATA_R/G/B active-low, S row select, COMM.
- All three colours are driven in the same row slot, so game logic no longer needs its own colour time-multiplexing.

---
 rtl/matrix_pkg.sv | 20 ++
 rtl/rgb_matrix_scanner_frame_bank.sv | 33 +++
 rtl/rgb_matrix_scanner.sv | 139 +++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared types for the 8x8 RGB matrix display path.
// Pixel rows carry one bit per column for each colour.
package matrix_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef struct packed {
        logic [COLS-1:0] r;
        logic [COLS-1:0] g;
        logic [COLS-1:0] b;
    } pix_row_t;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/rgb_matrix_scanner_frame_bank.sv
// Two-bank 8-row pixel store: one synchronous write port,
// one combinational read port.
module frame_bank
    import matrix_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     we_i,
    input  logic     wr_bank_i,
    input  logic [2:0] wr_row_i,
    input  pix_row_t wr_data_i,
    input  logic     rd_bank_i,
    input  logic [2:0] rd_row_i,
    output pix_row_t rd_data_o
);

    pix_row_t mem_q [2][ROWS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int bk = 0; bk < 2; bk++) begin
                for (int i = 0; i < ROWS; i++) begin
                    mem_q[bk][i] <= '0;
                end
            end
        end else if (we_i) begin
            mem_q[wr_bank_i][wr_row_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_bank_i][rd_row_i];

endmodule

// File: rtl/rgb_matrix_scanner.sv
// Row scanner for the 8x8 RGB matrix: double-buffered frames,
// blanked dwell start, swaps only on frame boundaries.
module rgb_matrix_scanner
    import matrix_pkg::*;
#(
    parameter int TICK_DIV     = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic       CLK,
    input  logic       Clear_n,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_r,
    input  logic [7:0] wr_g,
    input  logic [7:0] wr_b,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       frame_start,
    output logic [7:0] DATA_R,
    output logic [7:0] DATA_G,
    output logic [7:0] DATA_B,
    output logic [2:0] S,
    output logic       COMM
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

    scan_state_t   state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    row_q, row_d;
    logic          pend_q, pend_d;
    logic          sel_q, sel_d;
    logic          do_swap;
    logic          end_row;
    logic [7:0]    r_q, g_q, b_q;
    logic [2:0]    s_q;
    logic          ack_q, fs_q;
    pix_row_t      rd_data;
    pix_row_t      wr_data;

    assign wr_data = '{r: wr_r, g: wr_g, b: wr_b};

    // Back bank is always the one not selected before this edge.
    frame_bank u_bank (
        .clk_i     (CLK),
        .rst_ni    (Clear_n),
        .we_i      (wr_en),
        .wr_bank_i (~sel_q),
        .wr_row_i  (wr_row),
        .wr_data_i (wr_data),
        .rd_bank_i (sel_d),
        .rd_row_i  (row_d),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        row_d   = row_q;
        end_row = (state_q == SHOW) && (tick_q == TICK_LAST);
        do_swap = pend_q &&
                  ((end_row && row_q == 3'd7) || state_q == IDLE);
        sel_d   = sel_q ^ do_swap;
        pend_d  = (pend_q & ~do_swap) | swap_req;
        if (!enable) begin
            state_d = IDLE;
            tick_d  = '0;
            row_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    tick_d  = '0;
                    row_d   = '0;
                end
                BLANK: begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == BLANK_LAST) state_d = SHOW;
                end
                SHOW: begin
                    if (end_row) begin
                        tick_d  = '0;
                        row_d   = row_q + 3'd1;
                        state_d = BLANK;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                    row_d   = '0;
                end
            endcase
        end
    end

    // Pins are loaded from next-state so they track the scan state exactly.
    always_ff @(posedge CLK or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            row_q   <= '0;
            pend_q  <= 1'b0;
            sel_q   <= 1'b0;
            r_q     <= 8'hFF;
            g_q     <= 8'hFF;
            b_q     <= 8'hFF;
            s_q     <= '0;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            r_q     <= (state_d == SHOW) ? ~rd_data.r : 8'hFF;
            g_q     <= (state_d == SHOW) ? ~rd_data.g : 8'hFF;
            b_q     <= (state_d == SHOW) ? ~rd_data.b : 8'hFF;
            s_q     <= row_d;
            ack_q   <= do_swap;
            fs_q    <= (state_d == BLANK) && (state_q != BLANK) &&
                       (row_d == 3'd0);
        end
    end

    assign DATA_R      = r_q;
    assign DATA_G      = g_q;
    assign DATA_B      = b_q;
    assign S           = s_q;
    assign swap_ack    = ack_q;
    assign frame_start = fs_q;
    assign COMM        = 1'b1;

endmodule
